// File: rtl/touch_hold_controller.sv
// touch_hold_controller: turns a held touch into a colour-step request for one screen quadrant.
// Latency: quadrant registered 1 cycle after Coord_En; Change_Pulse 1 cycle after the HOLD_MS-th ms tick.
// Backpressure: none; Change_Pulse is a fire-and-forget strobe, the consumer must take it that cycle.
//
// Ports:
//   Clock, Resetn              - rising-edge clock, asynchronous active-low reset
//   Touch_En                   - touch present (level)
//   Coord_En, X_Coord, Y_Coord - coordinate strobe; only bit 11 of each coordinate selects the quadrant
//   Active_Quad, Quad_Valid    - currently held quadrant {Y[11], X[11]} and its qualifier
//   Change_Pulse, Change_Quad  - one-cycle step request and the quadrant it addresses
//   Hold_BCD                   - elapsed hold time in ms as four BCD digits, saturating at 9999
//
// Optional feature: define TOUCH_HOLD_REPEAT_EN to re-fire every HOLD_MS ms while the same quadrant
// stays held. Without it the controller locks after the first fire until the quadrant changes or the
// touch is released.
module touch_hold_controller #(
    parameter int CLK_PER_MS = 50000,
    parameter int HOLD_MS    = 1000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Touch_En,
    input  logic        Coord_En,
    input  logic [11:0] X_Coord,
    input  logic [11:0] Y_Coord,
    output logic [1:0]  Active_Quad,
    output logic        Quad_Valid,
    output logic        Change_Pulse,
    output logic [1:0]  Change_Quad,
    output logic [15:0] Hold_BCD
);

    // The ms counter has to be able to hold the value HOLD_MS itself, hence the +1.
    localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MS_W = $clog2(HOLD_MS + 1);

    localparam logic [31:0] PS_LAST   = CLK_PER_MS - 1;
    localparam logic [31:0] HOLD_MS_U = HOLD_MS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HOLD   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t            state;
    logic [PS_W-1:0]   presc;
    logic [MS_W-1:0]   ms_cnt;

    logic [1:0]        new_quad;
    logic              ms_tick;
    logic              ms_hit;
    logic              enter_hold;
    logic              unused_coord_bits;

    assign new_quad = {Y_Coord[11], X_Coord[11]};

    // Low coordinate bits carry sub-quadrant position we have no use for.
    assign unused_coord_bits = ^{X_Coord[10:0], Y_Coord[10:0]};

    assign ms_tick = (32'(presc) == PS_LAST);

    // Full-width compare against the value the counter is about to take on this tick.
    assign ms_hit = ((32'(ms_cnt) + 32'd1) == HOLD_MS_U);

    // A strobe starts (or restarts) a hold unless it only repeats the quadrant already being held.
    assign enter_hold = Coord_En &&
                        ((state == IDLE) || (state == ARMED) || (new_quad != Active_Quad));

    // BCD increment with ripple carry; parks at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            presc        <= '0;
            ms_cnt       <= '0;
            Active_Quad  <= 2'd0;
            Quad_Valid   <= 1'b0;
            Change_Pulse <= 1'b0;
            Change_Quad  <= 2'd0;
            Hold_BCD     <= 16'h0000;
        end else begin
            Change_Pulse <= 1'b0;
            if (!Touch_En) begin
                // Release wins over everything, including a fire due this cycle.
                state      <= IDLE;
                Quad_Valid <= 1'b0;
                Hold_BCD   <= 16'h0000;
                presc      <= '0;
                ms_cnt     <= '0;
            end else if (enter_hold) begin
                // A quadrant change wins over a coincident tick: counting restarts from zero.
                state       <= HOLD;
                Active_Quad <= new_quad;
                Quad_Valid  <= 1'b1;
                presc       <= '0;
                ms_cnt      <= '0;
                Hold_BCD    <= 16'h0000;
            end else begin
                case (state)
                    IDLE:  state <= ARMED;
                    ARMED: state <= ARMED;
                    HOLD, LOCKED: begin
                        if (ms_tick) begin
                            presc    <= '0;
                            Hold_BCD <= bcd_inc(Hold_BCD);
                            // LOCKED keeps the display running but the fire counter is frozen.
                            if (state == HOLD) begin
                                if (ms_hit) begin
                                    Change_Pulse <= 1'b1;
                                    Change_Quad  <= Active_Quad;
`ifdef TOUCH_HOLD_REPEAT_EN
                                    ms_cnt       <= '0;
`else
                                    ms_cnt       <= ms_cnt + 1'b1;
                                    state        <= LOCKED;
`endif
                                end else begin
                                    ms_cnt <= ms_cnt + 1'b1;
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_touch_hold_controller.sv
// tb_touch_hold_controller: directed checks of touch_hold_controller.
// Two instances share stimulus: a fast one (HOLD_MS=3) and one for saturation (HOLD_MS=9999).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_touch_hold_controller;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Touch_En;
    logic        Coord_En;
    logic [11:0] X_Coord;
    logic [11:0] Y_Coord;

    logic [1:0]  Active_Quad;
    logic        Quad_Valid;
    logic        Change_Pulse;
    logic [1:0]  Change_Quad;
    logic [15:0] Hold_BCD;

    logic [1:0]  s_active_quad;
    logic        s_quad_valid;
    logic        s_change_pulse;
    logic [1:0]  s_change_quad;
    logic [15:0] s_hold_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse tracking, cycle numbers relative to the last strobe (strobe cycle = 0).
    int         cyc;
    int         pulse_cnt;
    int         first_pulse_cyc;
    int         last_pulse_cyc;
    logic [1:0] pulse_quad;
    int         s_pulse_cnt;
    int         s_last_pulse_cyc;
    logic [1:0] s_pulse_quad;

    touch_hold_controller #(.CLK_PER_MS(4), .HOLD_MS(3)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Touch_En     (Touch_En),
        .Coord_En     (Coord_En),
        .X_Coord      (X_Coord),
        .Y_Coord      (Y_Coord),
        .Active_Quad  (Active_Quad),
        .Quad_Valid   (Quad_Valid),
        .Change_Pulse (Change_Pulse),
        .Change_Quad  (Change_Quad),
        .Hold_BCD     (Hold_BCD)
    );

    touch_hold_controller #(.CLK_PER_MS(4), .HOLD_MS(9999)) dut_sat (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Touch_En     (Touch_En),
        .Coord_En     (Coord_En),
        .X_Coord      (X_Coord),
        .Y_Coord      (Y_Coord),
        .Active_Quad  (s_active_quad),
        .Quad_Valid   (s_quad_valid),
        .Change_Pulse (s_change_pulse),
        .Change_Quad  (s_change_quad),
        .Hold_BCD     (s_hold_bcd)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_track();
        cyc              = 0;
        pulse_cnt        = 0;
        first_pulse_cyc  = -1;
        last_pulse_cyc   = -1;
        pulse_quad       = 2'd0;
        s_pulse_cnt      = 0;
        s_last_pulse_cyc = -1;
        s_pulse_quad     = 2'd0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            cyc++;
            if (Change_Pulse) begin
                pulse_cnt++;
                if (pulse_cnt == 1) first_pulse_cyc = cyc;
                last_pulse_cyc = cyc;
                pulse_quad     = Change_Quad;
            end
            if (s_change_pulse) begin
                s_pulse_cnt++;
                s_last_pulse_cyc = cyc;
                s_pulse_quad     = s_change_quad;
            end
        end
    endtask

    // Coordinate strobe with touch held; returns in cycle 1 with Coord_En low again.
    task automatic strobe(input logic [11:0] x, input logic [11:0] y);
        clear_track();
        Touch_En = 1'b1;
        X_Coord  = x;
        Y_Coord  = y;
        Coord_En = 1'b1;
        step(1);
        Coord_En = 1'b0;
    endtask

    task automatic release_touch();
        Touch_En = 1'b0;
        step(1);
    endtask

    initial begin
        Resetn   = 1'b0;
        Touch_En = 1'b0;
        Coord_En = 1'b0;
        X_Coord  = 12'h000;
        Y_Coord  = 12'h000;
        clear_track();
        #12;
        check("rst_active_quad", Active_Quad, 0);
        check("rst_quad_valid", Quad_Valid, 0);
        check("rst_change_pulse", Change_Pulse, 0);
        check("rst_change_quad", Change_Quad, 0);
        check("rst_hold_bcd", Hold_BCD, 16'h0000);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        step(2);

        // Basic hold, quadrant 1: pulse in cycle 13.
        strobe(12'h900, 12'h100);
        check("basic_quad", Active_Quad, 1);
        check("basic_valid", Quad_Valid, 1);
        check("basic_bcd_c1", Hold_BCD, 16'h0000);
        step(3);
        check("basic_bcd_c4", Hold_BCD, 16'h0000);
        step(1);
        check("basic_bcd_c5", Hold_BCD, 16'h0001);
        step(7);
        check("basic_no_early_pulse", pulse_cnt, 0);
        check("basic_bcd_c12", Hold_BCD, 16'h0002);
        step(1);
        check("basic_pulse_c13", Change_Pulse, 1);
        check("basic_change_quad", Change_Quad, 1);
        check("basic_bcd_c13", Hold_BCD, 16'h0003);
        step(1);
        check("basic_pulse_one_cycle", Change_Pulse, 0);
        check("basic_change_quad_held", Change_Quad, 1);
        release_touch();
        check("basic_rel_valid", Quad_Valid, 0);
        check("basic_rel_bcd", Hold_BCD, 16'h0000);
        check("basic_rel_change_quad", Change_Quad, 1);

        // Early release at cycle 10.
        strobe(12'h100, 12'h100);
        check("early_quad", Active_Quad, 0);
        step(8);
        check("early_bcd_c9", Hold_BCD, 16'h0002);
        step(1);
        Touch_En = 1'b0;
        step(1);
        check("early_valid", Quad_Valid, 0);
        check("early_bcd", Hold_BCD, 16'h0000);
        check("early_no_pulse", pulse_cnt, 0);

        // Release coinciding with the firing tick: no pulse.
        strobe(12'h900, 12'h100);
        step(11);
        Touch_En = 1'b0;
        step(1);
        check("relfire_pulse", Change_Pulse, 0);
        check("relfire_valid", Quad_Valid, 0);
        step(3);
        check("relfire_no_pulse", pulse_cnt, 0);

        // Same-quadrant strobe ignored, then switch to quadrant 2.
        strobe(12'h900, 12'h100);
        step(4);
        Coord_En = 1'b1;
        step(1);
        Coord_En = 1'b0;
        check("same_quad_kept", Active_Quad, 1);
        step(3);
        check("same_quad_bcd_c9", Hold_BCD, 16'h0002);
        check("same_quad_no_pulse", pulse_cnt, 0);
        strobe(12'h100, 12'h900);
        check("switch_quad", Active_Quad, 2);
        check("switch_valid", Quad_Valid, 1);
        check("switch_bcd", Hold_BCD, 16'h0000);
        step(12);
        check("switch_pulse_cnt", pulse_cnt, 1);
        check("switch_pulse_cyc", first_pulse_cyc, 13);
        check("switch_pulse_quad", pulse_quad, 2);
        release_touch();

        // Quadrant change on the firing tick: change wins, no pulse.
        strobe(12'h900, 12'h100);
        step(11);
        X_Coord  = 12'h100;
        Y_Coord  = 12'h900;
        Coord_En = 1'b1;
        step(1);
        Coord_En = 1'b0;
        check("chgtick_pulse", Change_Pulse, 0);
        check("chgtick_quad", Active_Quad, 2);
        check("chgtick_bcd", Hold_BCD, 16'h0000);
        release_touch();
        check("chgtick_no_pulse", pulse_cnt, 0);

        // Hold quadrant 3 for 10 ms.
        strobe(12'h900, 12'h900);
        step(40);
        check("mode_first_pulse", first_pulse_cyc, 13);
        check("mode_pulse_quad", pulse_quad, 3);
        check("mode_bcd_10ms", Hold_BCD, 16'h0010);
`ifdef TOUCH_HOLD_REPEAT_EN
        check("mode_pulse_cnt", pulse_cnt, 3);
        check("mode_last_pulse", last_pulse_cyc, 37);
`else
        check("mode_pulse_cnt", pulse_cnt, 1);
        check("mode_last_pulse", last_pulse_cyc, 13);
`endif
        release_touch();

        // Saturation: 10005 ms on quadrant 3.
        strobe(12'h900, 12'h900);
        step(4000);
        check("sat_bcd_1000", s_hold_bcd, 16'h1000);
        step(36019);
        check("sat_bcd", s_hold_bcd, 16'h9999);
        check("sat_bcd_fast", Hold_BCD, 16'h9999);
        check("sat_pulse_cnt", s_pulse_cnt, 1);
        check("sat_pulse_cyc", s_last_pulse_cyc, 39997);
        check("sat_pulse_quad", s_pulse_quad, 3);
        check("sat_pre_rst_quad", s_active_quad, 3);
        check("sat_pre_rst_valid", s_quad_valid, 1);

        // Asynchronous reset mid-hold, away from any clock edge.
        #3;
        Resetn = 1'b0;
        #1;
        check("arst_quad", Active_Quad, 0);
        check("arst_valid", Quad_Valid, 0);
        check("arst_pulse", Change_Pulse, 0);
        check("arst_change_quad", Change_Quad, 0);
        check("arst_bcd", Hold_BCD, 16'h0000);
        check("arst_sat_quad", s_active_quad, 0);
        check("arst_sat_valid", s_quad_valid, 0);
        check("arst_sat_change_quad", s_change_quad, 0);
        check("arst_sat_bcd", s_hold_bcd, 16'h0000);
        #2;
        Resetn = 1'b1;

        // Touch still present after reset: no hold without a fresh strobe.
        clear_track();
        step(20);
        check("post_rst_valid", Quad_Valid, 0);
        check("post_rst_bcd", Hold_BCD, 16'h0000);
        check("post_rst_no_pulse", pulse_cnt, 0);
        strobe(12'h100, 12'h900);
        check("post_rst_strobe_quad", Active_Quad, 2);
        check("post_rst_strobe_valid", Quad_Valid, 1);
        release_touch();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/touch_hold_controller.md
TOUCH_HOLD_CONTROLLER -- requirements
Module: touch_hold_controller

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 50000, meaning Clock cycles per millisecond tick.
REQ-002 SHALL have parameter HOLD_MS, default 1000, meaning the hold time in ms required to fire a change, legal range 1..9999.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port Resetn, input, 1 bit: the asynchronous, active-low reset.
REQ-005 SHALL have port Touch_En, input, 1 bit: touch present, level from the touch panel controller.
REQ-006 SHALL have port Coord_En, input, 1 bit: one-cycle strobe marking X_Coord/Y_Coord valid.
REQ-007 SHALL have ports X_Coord and Y_Coord, inputs, 12 bits each: touch coordinates; only bit 11 is used.
REQ-008 SHALL have port Active_Quad, output, 2 bits: the currently held quadrant.
REQ-009 SHALL have port Quad_Valid, output, 1 bit: Active_Quad is meaningful.
REQ-010 SHALL have port Change_Pulse, output, 1 bit: one-cycle request to step the colour of Change_Quad.
REQ-011 SHALL have port Change_Quad, output, 2 bits: the quadrant addressed by Change_Pulse.
REQ-012 SHALL have port Hold_BCD, output, 16 bits: four BCD digits of elapsed hold ms, saturating at 9999.

Function
REQ-013 SHALL map quadrants as {Y_Coord[11], X_Coord[11]}: 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
REQ-014 SHALL implement states IDLE, ARMED, HOLD and LOCKED.
REQ-015 SHALL move IDLE -> ARMED when Touch_En=1 and Coord_En=0.
REQ-016 SHALL move IDLE -> HOLD when Touch_En=1 and Coord_En=1 (stays in HOLD).
REQ-017 SHALL move ARMED -> HOLD on Coord_En=1 while Touch_En=1.
REQ-018 SHALL return to IDLE from any state, in the cycle after Touch_En=0, clearing Quad_Valid, Hold_BCD, the prescaler and the ms counter.
REQ-019 SHALL, on each transition into HOLD, register the quadrant so Active_Quad and Quad_Valid=1 appear the cycle after Coord_En, and clear the prescaler, ms counter and Hold_BCD.
REQ-020 SHALL, in HOLD, count the prescaler 0..CLK_PER_MS-1, generating a tick on the terminal count and wrapping to 0.
REQ-021 SHALL, on each tick, increment the ms counter and Hold_BCD (BCD ripple carry); Hold_BCD holds at 16'h9999 and does not wrap.
REQ-022 SHALL, when the ms counter reaches HOLD_MS on a tick, assert Change_Pulse for exactly one cycle on the following cycle, with Change_Quad = Active_Quad.
REQ-023 SHALL, on a Coord_En in HOLD whose quadrant is unchanged, have no effect on any counter.
REQ-024 SHALL, on a Coord_En in HOLD whose quadrant differs, take the REQ-019 behaviour with the new quadrant.
REQ-025 SHALL give a quadrant change priority over a tick in the same cycle: no pulse, counters cleared.
REQ-026 SHALL give Touch_En=0 priority over everything in the same cycle: no pulse issued.
REQ-027 SHALL hold Change_Quad at its last value while Change_Pulse=0.
REQ-028 SHALL size internal counters to ceil(log2) of their parameter, with ms counter compares done at full width.

Reset
REQ-029 SHALL, on Resetn=0, immediately (asynchronously) force the state to IDLE and outputs to: Active_Quad=0, Quad_Valid=0, Change_Pulse=0, Change_Quad=0, Hold_BCD=16'h0000.
REQ-030 SHALL, on reset asserted mid-HOLD, drop any pending pulse; after release, a new HOLD requires a fresh Coord_En.

Configuration
REQ-031 SHALL, with macro TOUCH_HOLD_REPEAT_EN defined, clear the ms counter after each fire, giving one Change_Pulse every HOLD_MS ms while the same quadrant is held; Hold_BCD continues counting.
REQ-032 SHALL, without TOUCH_HOLD_REPEAT_EN, move HOLD -> LOCKED after a fire. LOCKED issues no pulses and keeps Hold_BCD counting. A Coord_En in a different quadrant moves LOCKED -> HOLD per REQ-019, and Touch_En=0 moves LOCKED -> IDLE.

Verification (bench parameters CLK_PER_MS=4, HOLD_MS=3)
REQ-033 SHALL cover a basic hold: Touch_En=1 with Coord_En at X=12'h900, Y=12'h100 and held -> Active_Quad=1 one cycle later; Change_Pulse=1 for one cycle, Change_Quad=1, 13 cycles after the Coord_En cycle.
REQ-034 SHALL cover early release: Touch_En dropped 10 cycles after Coord_En -> no Change_Pulse; the next cycle shows Quad_Valid=0 and Hold_BCD=0.
REQ-035 SHALL cover a quadrant switch: after Hold_BCD=0002, Coord_En with X=12'h100, Y=12'h900 -> Active_Quad=2, Hold_BCD=0000, and a pulse with Change_Quad=2 three ms later.
REQ-036 SHALL cover mode behaviour: hold quadrant 3 for 10 ms -> pulses at 3, 6 and 9 ms with TOUCH_HOLD_REPEAT_EN, and a single pulse at 3 ms without it.
REQ-037 SHALL cover saturation and reset: use HOLD_MS=9999 and hold for 10005 ms -> Hold_BCD stays 16'h9999; asserting Resetn=0 mid-hold -> all outputs 0 without waiting for a Clock edge.
